// File: rtl/sc_stream_to_binary.sv
// Stochastic-to-binary converter: counts ones over a window of 2^W accepted bits
// and presents the result as a unipolar count and a signed bipolar value.
module sc_stream_to_binary #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                x_valid,
  input  logic                x,
  output logic                busy,
  output logic                done,
  output logic [W:0]          count_out,
  output logic signed [W+1:0] bipolar_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [W:0]   LAST_BIT    = {1'b0, {W{1'b1}}};
  localparam logic [W+1:0] OFFSET      = {2'b01, {W{1'b0}}};
  localparam logic [W+1:0] BIPOLAR_RST = {2'b11, {W{1'b0}}};

  logic [1:0]          state_q, state_d;
  logic [W:0]          bitCnt_q, bitCnt_d;
  logic [W:0]          onesAcc_q, onesAcc_d;
  logic [W:0]          count_q, count_d;
  logic signed [W+1:0] bipolar_q, bipolar_d;
  logic [W:0]          onesNext;

  // Results are latched only when the final bit of the window is accepted,
  // so count and bipolar always describe the last completed window.
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    onesAcc_d = onesAcc_q;
    count_d   = count_q;
    bipolar_d = bipolar_q;
    onesNext  = onesAcc_q + {{W{1'b0}}, x};
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          bitCnt_d  = '0;
          onesAcc_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (x_valid) begin
          bitCnt_d  = bitCnt_q + 1'b1;
          onesAcc_d = onesNext;
          if (bitCnt_q == LAST_BIT) begin
            state_d   = DONE;
            count_d   = onesNext;
            bipolar_d = $signed({onesNext, 1'b0} - OFFSET);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      onesAcc_q <= '0;
      count_q   <= '0;
      bipolar_q <= $signed(BIPOLAR_RST);
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      onesAcc_q <= onesAcc_d;
      count_q   <= count_d;
      bipolar_q <= bipolar_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign count_out   = count_q;
  assign bipolar_out = bipolar_q;

endmodule
